// File: rtl/ecg_nn_pkg.sv
// rtl/ecg_nn_pkg.sv - shared constants, state type and ADC conversion for the ECG classifier front end
package ecg_nn_pkg;

    localparam int NTAPS        = 10;
    localparam int ADC_MIDSCALE = 2048;
    localparam int NODE_LATENCY = 3;
    localparam int DATA_W       = 24;
    localparam int ADC_W        = 12;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Offset-binary to two's complement: subtracting midscale modulo 2^12
    // leaves the signed 12-bit value, which is then sign-extended.
    function automatic logic [DATA_W-1:0] adc_to_signed(input logic [ADC_W-1:0] code);
        logic [ADC_W-1:0] centred;
        centred = code - ADC_W'(ADC_MIDSCALE);
        return {{(DATA_W-ADC_W){centred[ADC_W-1]}}, centred};
    endfunction

endpackage

// File: rtl/ecg_sample_shift.sv
// rtl/ecg_sample_shift.sv - NTAPS x 24-bit sample shift register with shift enable and synchronous zero
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   zero   in   synchronous clear of all taps
//   shift  in   advance the register by one sample
//   din    in   new sample, enters at tap NTAPS-1
//   taps   out  current contents, tap 0 oldest
module ecg_sample_shift
    import ecg_nn_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          zero,
    input  logic                          shift,
    input  logic [DATA_W-1:0]             din,
    output logic [NTAPS-1:0][DATA_W-1:0]  taps
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taps <= '0;
        end else if (zero) begin
            taps <= '0;
        end else if (shift) begin
            taps <= {din, taps[NTAPS-1:1]};
        end
    end

endmodule

// File: rtl/ecg_window_buffer.sv
// rtl/ecg_window_buffer.sv - ADC sample intake, 10-sample sliding window and first-layer valid timing
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   synchronous flush, active-high
//   s_valid    in   sample offered
//   s_ready    out  sample accepted when s_valid && s_ready
//   s_data     in   12-bit offset-binary ADC sample
//   A0x..A9x   out  24-bit signed window, A0x oldest, A9x newest
//   win_valid  out  one-cycle pulse when A0x..A9x are updated
//   n_valid    out  win_valid delayed by the node pipeline latency
module ecg_window_buffer
    import ecg_nn_pkg::*;
#(
    parameter int STRIDE   = 5,
    parameter int GAP_CYC  = 2,
    parameter int IN_SHIFT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADC_W-1:0]  s_data,
    output logic [DATA_W-1:0] A0x,
    output logic [DATA_W-1:0] A1x,
    output logic [DATA_W-1:0] A2x,
    output logic [DATA_W-1:0] A3x,
    output logic [DATA_W-1:0] A4x,
    output logic [DATA_W-1:0] A5x,
    output logic [DATA_W-1:0] A6x,
    output logic [DATA_W-1:0] A7x,
    output logic [DATA_W-1:0] A8x,
    output logic [DATA_W-1:0] A9x,
    output logic              win_valid,
    output logic              n_valid
);

    localparam logic [3:0] FILL_LAST   = 4'(NTAPS - 1);
    localparam logic [3:0] STRIDE_LAST = 4'(STRIDE - 1);
    localparam logic [2:0] GAP_LAST    = 3'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    state_t                          state;
    logic [3:0]                      fill_cnt;
    logic [3:0]                      stride_cnt;
    logic [2:0]                      gap_cnt;
    logic                            ready_q;
    logic [NODE_LATENCY-1:0]         nv_pipe;
    logic [NTAPS-1:0][DATA_W-1:0]    taps;
    logic [NTAPS-1:0][DATA_W-1:0]    win_q;
    logic [NTAPS-1:0][DATA_W-1:0]    win_next;
    logic [DATA_W-1:0]               sample;
    logic                            accept;
    logic                            emit;

    // clear blocks intake combinationally so a sample offered with clear is dropped.
    assign s_ready = ready_q & ~clear;
    assign accept  = s_valid & s_ready;
    assign sample  = adc_to_signed(s_data) << IN_SHIFT;

    // The emitted window includes the sample being accepted on this edge,
    // so it is taken from the register's next contents, not its current ones.
    assign win_next = {sample, taps[NTAPS-1:1]};

    assign emit = accept && (((state == FILL) && (fill_cnt == FILL_LAST)) ||
                             ((state == RUN)  && (stride_cnt == STRIDE_LAST)));

    ecg_sample_shift u_shift (
        .clk   (clk),
        .reset (reset),
        .zero  (clear),
        .shift (accept),
        .din   (sample),
        .taps  (taps)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            fill_cnt   <= '0;
            stride_cnt <= '0;
            gap_cnt    <= '0;
            ready_q    <= 1'b0;
            win_valid  <= 1'b0;
            nv_pipe    <= '0;
            win_q      <= '0;
        end else if (clear) begin
            state      <= FILL;
            fill_cnt   <= '0;
            stride_cnt <= '0;
            gap_cnt    <= '0;
            ready_q    <= 1'b1;
            win_valid  <= 1'b0;
            nv_pipe    <= '0;
        end else begin
            win_valid <= emit;
            nv_pipe   <= {nv_pipe[NODE_LATENCY-2:0], win_valid};
            if (emit) begin
                win_q <= win_next;
            end
            case (state)
                FILL: begin
                    ready_q <= 1'b1;
                    if (emit) begin
                        fill_cnt   <= '0;
                        stride_cnt <= '0;
                        gap_cnt    <= '0;
                        if (GAP_CYC == 0) begin
                            state <= RUN;
                        end else begin
                            state   <= GAP;
                            ready_q <= 1'b0;
                        end
                    end else if (accept) begin
                        fill_cnt <= fill_cnt + 4'd1;
                    end
                end
                RUN: begin
                    ready_q <= 1'b1;
                    if (emit) begin
                        stride_cnt <= '0;
                        gap_cnt    <= '0;
                        if (GAP_CYC != 0) begin
                            state   <= GAP;
                            ready_q <= 1'b0;
                        end
                    end else if (accept) begin
                        stride_cnt <= stride_cnt + 4'd1;
                    end
                end
                GAP: begin
                    // ready rises on the edge that ends the last gap cycle
                    if (gap_cnt == GAP_LAST) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end
                default: begin
                    state   <= FILL;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign n_valid = nv_pipe[NODE_LATENCY-1];

    assign A0x = win_q[0];
    assign A1x = win_q[1];
    assign A2x = win_q[2];
    assign A3x = win_q[3];
    assign A4x = win_q[4];
    assign A5x = win_q[5];
    assign A6x = win_q[6];
    assign A7x = win_q[7];
    assign A8x = win_q[8];
    assign A9x = win_q[9];

endmodule
